// File: rtl/axis_round_robin_interconnect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_round_robin_interconnect: N-to-1 AXI-Stream packet mux, round-robin |
// | arbitration, grant locked until tlast. Option macro: AXIS_RR_OUT_REG_EN  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_round_robin_interconnect #(
  parameter int PORTS_QTY   = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic [PORTS_QTY-1:0]                    s_axis_data_tvalid,
  output logic [PORTS_QTY-1:0]                    s_axis_data_tready,
  input  logic [PORTS_QTY-1:0]                    s_axis_data_tlast,
  input  logic [PORTS_QTY-1:0][TDATA_WIDTH-1:0]   s_axis_data_tdata,
  input  logic [PORTS_QTY-1:0][TUSER_WIDTH-1:0]   s_axis_data_tuser,
  output logic                                    m_axis_data_tvalid,
  input  logic                                    m_axis_data_tready,
  output logic                                    m_axis_data_tlast,
  output logic [TDATA_WIDTH-1:0]                  m_axis_data_tdata,
  output logic [TUSER_WIDTH-1:0]                  m_axis_data_tuser
);

  localparam int IDX_W = (PORTS_QTY > 1) ? $clog2(PORTS_QTY) : 1;
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(PORTS_QTY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  // The most recent grant doubles as the active grant while BUSY.
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic             found_w;
  logic [IDX_W-1:0] sel_w;
  logic [IDX_W-1:0] idx_w;
  logic             busy_w;
  logic             out_ready_w;
  logic             accept_w;

  assign busy_w   = (state_q == BUSY);
  assign accept_w = busy_w & s_axis_data_tvalid[last_grant_q] & out_ready_w;

  always_comb begin
    found_w = 1'b0;
    sel_w   = '0;
    idx_w   = '0;
    for (int k = 1; k <= PORTS_QTY; k++) begin
      idx_w = IDX_W'((int'(last_grant_q) + k) % PORTS_QTY);
      if (!found_w && s_axis_data_tvalid[idx_w]) begin
        found_w = 1'b1;
        sel_w   = idx_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_PORT;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (found_w) begin
          last_grant_d = sel_w;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (accept_w && s_axis_data_tlast[last_grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < PORTS_QTY; g++) begin : g_ready
    assign s_axis_data_tready[g] = busy_w && (last_grant_q == IDX_W'(g)) && out_ready_w;
  end

`ifdef AXIS_RR_OUT_REG_EN
  logic                   m_valid_q;
  logic                   m_last_q;
  logic [TDATA_WIDTH-1:0] m_data_q;
  logic [TUSER_WIDTH-1:0] m_user_q;

  // A held beat frees the stage in the same cycle it is consumed.
  assign out_ready_w = !m_valid_q || m_axis_data_tready;

  always_ff @(posedge clk) begin
    if (resetn) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= '0;
    end else if (accept_w) begin
      m_valid_q <= 1'b1;
      m_last_q  <= s_axis_data_tlast[last_grant_q];
      m_data_q  <= s_axis_data_tdata[last_grant_q];
      m_user_q  <= s_axis_data_tuser[last_grant_q];
    end else if (m_axis_data_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_axis_data_tvalid = m_valid_q;
  assign m_axis_data_tlast  = m_last_q;
  assign m_axis_data_tdata  = m_data_q;
  assign m_axis_data_tuser  = m_user_q;
`else
  assign out_ready_w        = m_axis_data_tready;
  assign m_axis_data_tvalid = busy_w & s_axis_data_tvalid[last_grant_q];
  assign m_axis_data_tlast  = busy_w & s_axis_data_tlast[last_grant_q];
  assign m_axis_data_tdata  = busy_w ? s_axis_data_tdata[last_grant_q] : '0;
  assign m_axis_data_tuser  = busy_w ? s_axis_data_tuser[last_grant_q] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_round_robin_interconnect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_round_robin_interconnect: randomized bench with packet-level     |
// | reference model for axis_round_robin_interconnect. Revision: 1.0         |
// +--------------------------------------------------------------------------+
module tb_axis_round_robin_interconnect;

  localparam int P = 4;

  typedef struct {
    logic [31:0] d;
    logic [15:0] u;
    logic        l;
    int          gap;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [P-1:0]      s_tvalid, s_tready, s_tlast;
  logic [P-1:0][31:0] s_tdata;
  logic [P-1:0][15:0] s_tuser;
  logic              m_tvalid, m_tready, m_tlast;
  logic [31:0]       m_tdata;
  logic [15:0]       m_tuser;

  axis_round_robin_interconnect #(
    .PORTS_QTY  (P),
    .TDATA_WIDTH(32),
    .TUSER_WIDTH(16)
  ) dut (
    .clk               (clk),
    .resetn            (rst),
    .s_axis_data_tvalid(s_tvalid),
    .s_axis_data_tready(s_tready),
    .s_axis_data_tlast (s_tlast),
    .s_axis_data_tdata (s_tdata),
    .s_axis_data_tuser (s_tuser),
    .m_axis_data_tvalid(m_tvalid),
    .m_axis_data_tready(m_tready),
    .m_axis_data_tlast (m_tlast),
    .m_axis_data_tdata (m_tdata),
    .m_axis_data_tuser (m_tuser)
  );

  always #5 clk = ~clk;

  int    vecs  = 0;
  int    fails = 0;
  logic  rst_req;
  int    rdy_pct;

  // Stimulus: per-port beat queues, each beat preceded by `gap` idle cycles.
  beat_t txq[P][$];
  int    len_q[P][$];
  int    gapc[P];
  bit    loaded[P];
  bit    acc[P];

  // Packet-level model: which port must win each arbitration.
  bit    pend;
  int    mlast;
  int    pred_in;
  int    pred_q[$];
  int    obs_order[$];

  bit    out_active;
  int    out_port, out_idx, out_len;
  bit    prev_hold;
  logic [48:0] prev_out;

  function automatic bit all_done();
    bit r = !out_active && (pred_q.size() == 0);
    for (int p = 0; p < P; p++)
      if (txq[p].size() != 0 || len_q[p].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic cycle();
    logic [P-1:0] mask;
    bit found;
    int c;
    @(negedge clk);
    rst = rst_req;
    for (int p = 0; p < P; p++) begin
      if (acc[p]) begin
        void'(txq[p].pop_front());
        loaded[p] = 1'b0;
      end
      if (txq[p].size() > 0 && !loaded[p]) begin
        gapc[p]   = txq[p][0].gap;
        loaded[p] = 1'b1;
      end
      if (txq[p].size() > 0 && gapc[p] == 0) begin
        s_tvalid[p] = 1'b1;
        s_tdata[p]  = txq[p][0].d;
        s_tuser[p]  = txq[p][0].u;
        s_tlast[p]  = txq[p][0].l;
      end else begin
        s_tvalid[p] = 1'b0;
        s_tdata[p]  = '0;
        s_tuser[p]  = '0;
        s_tlast[p]  = 1'b0;
        if (gapc[p] > 0) gapc[p]--;
      end
    end
    m_tready = ($urandom_range(99, 0) < rdy_pct);
    #1;
    for (int p = 0; p < P; p++) acc[p] = s_tvalid[p] & s_tready[p];

    if (rst) begin
      vecs++;
      if (m_tvalid !== 1'b0 || s_tready !== '0) begin
        fails++;
        $display("FAIL reset_handshake: m_tvalid=%b s_tready=%b, required 0/0000", m_tvalid, s_tready);
      end
      vecs++;
      if ({m_tlast, m_tdata, m_tuser} !== 49'd0) begin
        fails++;
        $display("FAIL reset_outputs: tlast=%b tdata=%h tuser=%h, required all zero", m_tlast, m_tdata, m_tuser);
      end
      for (int p = 0; p < P; p++) acc[p] = 1'b0;
      pend = 1'b1; mlast = P - 1; pred_in = 0; pred_q.delete();
      out_active = 1'b0; prev_hold = 1'b0;
    end else begin
      if (pend) begin
        vecs++;
        if (s_tready !== '0) begin
          fails++;
          $display("FAIL arb_gap_ready: s_tready=%b while arbitrating, required 0000", s_tready);
        end
        found = 1'b0;
        for (int k = 1; k <= P; k++) begin
          c = (mlast + k) % P;
          if (!found && s_tvalid[c]) begin
            found = 1'b1; pred_in = c;
          end
        end
        if (found) begin
          mlast = pred_in; pend = 1'b0; pred_q.push_back(pred_in);
        end
      end else begin
        mask = ~(4'b0001 << pred_in);
        vecs++;
        if ((s_tready & mask) !== '0) begin
          fails++;
          $display("FAIL lock_ready: s_tready=%b, only port %0d may be ready", s_tready, pred_in);
        end
        if (acc[pred_in] && s_tlast[pred_in]) pend = 1'b1;
      end

      if (prev_hold) begin
        vecs++;
        if ({m_tvalid, m_tlast, m_tdata, m_tuser} !== {1'b1, prev_out}) begin
          fails++;
          $display("FAIL out_stable: got v=%b %h, required v=1 %h while stalled",
                   m_tvalid, {m_tlast, m_tdata, m_tuser}, prev_out);
        end
      end
      prev_hold = m_tvalid && !m_tready;
      prev_out  = {m_tlast, m_tdata, m_tuser};

      if (m_tvalid && m_tready) begin
        if (!out_active) begin
          obs_order.push_back(int'(m_tuser));
          vecs++;
          if (pred_q.size() == 0) begin
            fails++;
            $display("FAIL out_unexpected_pkt: tuser=%0d started, required no packet", m_tuser);
            out_port = int'(m_tuser);
          end else begin
            out_port = pred_q.pop_front();
          end
          if (out_port >= 0 && out_port < P && len_q[out_port].size() > 0)
            out_len = len_q[out_port].pop_front();
          else
            out_len = 1;
          out_idx    = 0;
          out_active = 1'b1;
        end
        vecs++;
        if (m_tuser !== 16'(out_port) || m_tdata !== 32'(out_idx) || m_tlast !== (out_idx == out_len - 1)) begin
          fails++;
          $display("FAIL out_beat: got tuser=%0d tdata=%0d tlast=%b, required tuser=%0d tdata=%0d tlast=%b",
                   m_tuser, m_tdata, m_tlast, out_port, out_idx, (out_idx == out_len - 1));
        end
        out_idx++;
        if (out_idx >= out_len) out_active = 1'b0;
      end
    end
  endtask

  task automatic add_pkt(input int p, input int len, input int gapmax, input int firstgap);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = 32'(i);
      b.u   = 16'(p);
      b.l   = (i == len - 1);
      b.gap = (i == 0) ? firstgap : int'($urandom_range(gapmax, 0));
      txq[p].push_back(b);
    end
    len_q[p].push_back(len);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    vecs++;
    if (!all_done()) begin
      fails++;
      $display("FAIL %s_drain: traffic pending after %0d cycles, required all delivered", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_req = 1'b1;
    for (int p = 0; p < P; p++) add_pkt(p, 3, 0, 0);
    @(posedge clk);
    repeat (40) cycle();
    rst_req = 1'b0;
    obs_order.delete();
    cycle();
    cycle();
    vecs++;
    if (s_tready !== 4'b0001) begin
      fails++;
      $display("FAIL first_grant: s_tready=%b, required 0001", s_tready);
    end
    drain(200, "reset");
    vecs++;
    if (obs_order.size() == 0 || obs_order[0] !== 0) begin
      fails++;
      $display("FAIL first_pkt_port: got %0d packets, first port %0d, required port 0",
               obs_order.size(), (obs_order.size() > 0) ? obs_order[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    obs_order.delete();
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < P; p++) add_pkt(p, 3, 0, 0);
    drain(400, "rr");
    vecs++;
    if (obs_order.size() !== 16) begin
      fails++;
      $display("FAIL rr_count: got %0d packets, required 16", obs_order.size());
    end
    for (int i = 0; i < obs_order.size(); i++) begin
      vecs++;
      if (obs_order[i] !== i % P) begin
        fails++;
        $display("FAIL rr_order[%0d]: got port %0d, required %0d", i, obs_order[i], i % P);
      end
    end
  endtask

  task automatic test_lock();
    int n = 0;
    int bad = 0;
    obs_order.delete();
    add_pkt(1, 1000, 2, 0);
    add_pkt(2, 3, 0, 0);
    while (txq[1].size() > 0 && n < 6000) begin
      cycle();
      if (s_tready[2]) bad++;
      n++;
    end
    vecs++;
    if (bad !== 0 || n >= 6000) begin
      fails++;
      $display("FAIL lock_port2_ready: port 2 ready %0d cycles (%0d cycles run), required 0", bad, n);
    end
    drain(200, "lock");
    vecs++;
    if (obs_order.size() !== 2 || obs_order[0] !== 1 || obs_order[1] !== 2) begin
      fails++;
      $display("FAIL lock_order: got %0d packets first=%0d, required ports 1 then 2",
               obs_order.size(), (obs_order.size() > 0) ? obs_order[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    int n3 = 0;
    obs_order.delete();
    for (int i = 0; i < 8; i++) add_pkt(3, 1, 0, 0);
    drain(100, "single");
    foreach (obs_order[i]) if (obs_order[i] == 3) n3++;
    vecs++;
    if (n3 !== 8 || obs_order.size() !== 8) begin
      fails++;
      $display("FAIL single_beat_count: got %0d of %0d packets from port 3, required 8 of 8",
               n3, obs_order.size());
    end
  endtask

  task automatic test_random_backpressure();
    int cnt[P];
    obs_order.delete();
    rdy_pct = 50;
    for (int i = 0; i < 15; i++)
      for (int p = 0; p < P; p++)
        add_pkt(p, int'($urandom_range(40, 1)), 2, int'($urandom_range(3, 0)));
    drain(20000, "random");
    rdy_pct = 100;
    for (int p = 0; p < P; p++) cnt[p] = 0;
    foreach (obs_order[i]) if (obs_order[i] >= 0 && obs_order[i] < P) cnt[obs_order[i]]++;
    for (int p = 0; p < P; p++) begin
      vecs++;
      if (cnt[p] !== 15) begin
        fails++;
        $display("FAIL random_pkts_port%0d: got %0d packets, required 15", p, cnt[p]);
      end
    end
  endtask

  task automatic test_idle_port();
    int i10 = -1;
    int i11 = -1;
    int n1  = 0;
    int e;
    obs_order.delete();
    for (int i = 0; i < 60; i++)
      for (int p = 0; p < P; p++) begin
        if (p != 1) add_pkt(p, int'($urandom_range(8, 1)), 0, 0);
        else if (i < 11) add_pkt(1, int'($urandom_range(8, 1)), 0, (i == 10) ? 200 : 0);
      end
    drain(5000, "idle");
    foreach (obs_order[i]) if (obs_order[i] == 1) begin
      n1++;
      if (n1 == 10) i10 = i;
      if (n1 == 11) i11 = i;
    end
    vecs++;
    if (n1 !== 11 || obs_order.size() !== 191 || i11 < 0 || i11 >= obs_order.size() - 1) begin
      fails++;
      $display("FAIL idle_rejoin: port1 packets=%0d total=%0d rejoin_idx=%0d, required 11/191 and rejoin before end",
               n1, obs_order.size(), i11);
    end
    if (i10 >= 0 && i11 > i10) begin
      for (int j = i10 + 1; j < i11; j++) begin
        e = (obs_order[j-1] <= 1) ? 2 : (obs_order[j-1] == 2) ? 3 : 0;
        vecs++;
        if (obs_order[j] !== e) begin
          fails++;
          $display("FAIL idle_rotation[%0d]: got port %0d, required %0d", j, obs_order[j], e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rst_req = 1'b1; rdy_pct = 100;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tuser = '0; m_tready = 1'b0;
    pend = 1'b1; mlast = P - 1; pred_in = 0;
    out_active = 1'b0; out_port = 0; out_idx = 0; out_len = 1;
    prev_hold = 1'b0; prev_out = '0;
    for (int p = 0; p < P; p++) begin
      gapc[p] = 0; loaded[p] = 1'b0; acc[p] = 1'b0;
    end
    test_reset();
    test_round_robin();
    test_lock();
    test_back_to_back();
    test_random_backpressure();
    test_idle_port();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
`default_nettype wire
